// File: rtl/epp_host_master.sv
// EPP host initiator: runs one address/data read or write cycle per command
// using the four-phase strobe/WAIT handshake, with a per-phase timeout.
module epp_host_master #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST_ASYNC,
  input  logic       CMD_VALID_IN,
  output logic       CMD_READY_OUT,
  input  logic       CMD_ADDR_IN,
  input  logic       CMD_WRITE_IN,
  input  logic [7:0] CMD_WDATA_IN,
  output logic       DONE_OUT,
  output logic       ERR_OUT,
  output logic [7:0] RD_DATA_OUT,
  output logic       EPP_ASTB_OUT,
  output logic       EPP_DSTB_OUT,
  output logic       EPP_WRITE_OUT,
  output logic [7:0] EPP_DATA_OUT,
  output logic       EPP_DATA_OE_OUT,
  input  logic [7:0] EPP_DATA_IN,
  input  logic       EPP_WAIT_IN
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SLOAD = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, DONE
  } state_t;

  state_t state, nxt;

  logic [1:0]    wait_sync;
  logic          wait_s;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          is_addr;
  logic          abort;
  logic          accept;
  logic          tmo;

  assign wait_s = wait_sync[1];
  assign accept = CMD_VALID_IN && (state == IDLE);
  assign tmo    = (tcnt == TMAX);

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = SETUP;
      SETUP:   if (scnt == '0) nxt = STROBE;
      STROBE:  if (wait_s) nxt = RELEASE;
               else if (tmo) nxt = DONE;
      RELEASE: if (!wait_s || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY_OUT = (state == IDLE);
    DONE_OUT      = (state == DONE);
    ERR_OUT       = (state == DONE) && abort;
  end

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) wait_sync <= 2'b00;
    else           wait_sync <= {wait_sync[0], EPP_WAIT_IN};
  end

  // Strobes, bus drive and read capture are registered so the pins never glitch.
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      EPP_ASTB_OUT    <= 1'b1;
      EPP_DSTB_OUT    <= 1'b1;
      EPP_WRITE_OUT   <= 1'b1;
      EPP_DATA_OUT    <= 8'h00;
      EPP_DATA_OE_OUT <= 1'b0;
      RD_DATA_OUT     <= 8'h00;
      scnt            <= '0;
      tcnt            <= '0;
      is_addr         <= 1'b0;
      abort           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          EPP_WRITE_OUT   <= ~CMD_WRITE_IN;
          EPP_DATA_OUT    <= CMD_WRITE_IN ? CMD_WDATA_IN : 8'h00;
          EPP_DATA_OE_OUT <= CMD_WRITE_IN;
          is_addr         <= CMD_ADDR_IN;
          abort           <= 1'b0;
          scnt            <= SLOAD;
        end
        SETUP: begin
          if (scnt == '0) begin
            EPP_ASTB_OUT <= ~is_addr;
            EPP_DSTB_OUT <= is_addr;
            tcnt         <= '0;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        STROBE: begin
          if (wait_s) begin
            EPP_ASTB_OUT <= 1'b1;
            EPP_DSTB_OUT <= 1'b1;
            tcnt         <= '0;
            if (EPP_WRITE_OUT) RD_DATA_OUT <= EPP_DATA_IN;
          end else if (tmo) begin
            EPP_ASTB_OUT    <= 1'b1;
            EPP_DSTB_OUT    <= 1'b1;
            EPP_WRITE_OUT   <= 1'b1;
            EPP_DATA_OUT    <= 8'h00;
            EPP_DATA_OE_OUT <= 1'b0;
            abort           <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!wait_s || tmo) begin
            EPP_WRITE_OUT   <= 1'b1;
            EPP_DATA_OUT    <= 8'h00;
            EPP_DATA_OE_OUT <= 1'b0;
            abort           <= wait_s;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_epp_host_master.sv
// Bench for epp_host_master: cycle-level responder plus outcome model
// derived from the strobe/WAIT timing rules.
module tb_epp_host_master;

  localparam int SETUP = 2;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, ready, addr, wr;
  logic [7:0] wdata;
  logic       done, err;
  logic [7:0] rd_data;
  logic       astb, dstb, write_n, oe;
  logic [7:0] data_out, pdata;
  logic       waitin;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_done = 0;
  int last_acc  = 0;
  logic [7:0] rd_ref = 8'h00;

  epp_host_master #(
    .SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .RST_ASYNC(rst),
    .CMD_VALID_IN(valid),
    .CMD_READY_OUT(ready),
    .CMD_ADDR_IN(addr),
    .CMD_WRITE_IN(wr),
    .CMD_WDATA_IN(wdata),
    .DONE_OUT(done),
    .ERR_OUT(err),
    .RD_DATA_OUT(rd_data),
    .EPP_ASTB_OUT(astb),
    .EPP_DSTB_OUT(dstb),
    .EPP_WRITE_OUT(write_n),
    .EPP_DATA_OUT(data_out),
    .EPP_DATA_OE_OUT(oe),
    .EPP_DATA_IN(pdata),
    .EPP_WAIT_IN(waitin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // d/e: cycles from strobe fall to WAIT rise / strobe rise to WAIT fall;
  // negative means the responder never makes that transition.
  task automatic run_cmd(input bit a, input bit w, input logic [7:0] wd,
                         input logic [7:0] rdv, input int d, input int e,
                         input bit hold);
    int c, s, r, low_n, done_c, exp_low, exp_done;
    bit raised, ovl, wrong, badbus, got, exp_err, acked, err_seen;
    logic [7:0] exp_data, rd_seen;
    logic [11:0] rel;
    s = -1; r = -1; low_n = 0; done_c = -1;
    raised = 0; ovl = 0; wrong = 0; badbus = 0; got = 0;
    err_seen = 0; rd_seen = 8'hxx; rel = 12'hxxx;
    exp_data = w ? wd : 8'h00;
    @(negedge clk);
    check("ready_idle", ready, 1);
    check("done_idle", done, 0);
    last_acc = cyc;
    valid = 1'b1; addr = a; wr = w; wdata = wd;
    for (c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) valid = 1'b0;
      if (!astb && !dstb) ovl = 1;
      if (a ? !dstb : !astb) wrong = 1;
      if (!astb || !dstb) begin
        low_n++;
        if (s < 0) s = c;
      end else if (s >= 0 && r < 0) begin
        r = c;
      end
      if (done) begin
        got = 1; done_c = c; err_seen = err; rd_seen = rd_data;
        rel = {astb, dstb, write_n, oe, data_out};
        last_done = cyc;
      end else begin
        if (write_n !== ~w || oe !== w || data_out !== exp_data) badbus = 1;
        if (!raised && s >= 0 && r < 0 && d >= 0 && c - s == d) begin
          waitin = 1'b1; pdata = rdv; raised = 1;
        end
        if (raised && r >= 0 && e >= 0 && c - r == e) waitin = 1'b0;
      end
    end
    waitin = 1'b0;
    pdata = 8'($urandom);
    if (d < 0 || d + 3 > TMO) begin
      acked = 0; exp_err = 1; exp_low = TMO;
      exp_done = SETUP + 1 + TMO;
    end else begin
      acked = 1; exp_low = d + 3;
      if (e < 0 || e + 3 > TMO) begin
        exp_err = 1; exp_done = SETUP + 1 + d + 3 + TMO;
      end else begin
        exp_err = 0; exp_done = SETUP + 1 + d + 3 + e + 3;
      end
    end
    if (acked && !w) rd_ref = rdv;
    check("done_seen", got, 1);
    check("done_cycle", done_c, exp_done);
    check("err", err_seen, exp_err);
    check("rd_data", rd_seen, rd_ref);
    check("strobe_first", s, SETUP + 1);
    check("strobe_len", low_n, exp_low);
    check("strobe_overlap", ovl, 0);
    check("wrong_strobe", wrong, 0);
    check("bus_held", badbus, 0);
    check("bus_release", rel, 12'hE00);
  endtask

  initial begin
    bit saw;
    int d, e;
    rst = 1'b1; valid = 1'b0; addr = 1'b0; wr = 1'b0;
    wdata = 8'h00; waitin = 1'b0; pdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state",
          {ready, done, err, astb, dstb, write_n, oe, data_out, rd_data},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
    rst = 1'b0;

    run_cmd(1, 1, 8'h05, 8'h00, 3, 2, 0);
    run_cmd(0, 0, 8'h00, 8'hA5, 2, 1, 0);
    run_cmd(0, 0, 8'h00, 8'h5A, -1, 0, 0);
    run_cmd(0, 1, 8'hC3, 8'h00, 1, -1, 0);
    run_cmd(0, 0, 8'h00, 8'h11, 13, 0, 0);
    run_cmd(0, 0, 8'h00, 8'h22, 14, 0, 0);
    run_cmd(1, 1, 8'h44, 8'h00, 0, 13, 0);
    run_cmd(1, 0, 8'h00, 8'h66, 0, 14, 0);

    run_cmd(1, 1, 8'h01, 8'h00, 2, 2, 1);
    d = last_done;
    run_cmd(0, 1, 8'h3C, 8'h00, 4, 1, 0);
    check("b2b_spacing", last_acc - d, 1);

    @(negedge clk);
    valid = 1'b1; addr = 1'b0; wr = 1'b1; wdata = 8'h77;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 20 && dstb; i++) @(negedge clk);
    check("rst_dstb_pre", {dstb, oe}, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("rst_async", {dstb, astb, oe, write_n}, 4'b1101);
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("rst_no_done", saw, 0);
    rst = 1'b0;
    rd_ref = 8'h00;
    run_cmd(0, 0, 8'h00, 8'h9E, 2, 2, 0);

    for (int i = 0; i < 30; i++) begin
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 15));
      e = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 15));
      run_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              d, e, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/epp_host_master.md
# epp_host_master

Bench-side and board-side EPP host initiator: the opposite end of the FPGA_TOP EPP peripheral port (EPP_ASTB/EPP_DSTB strobes in, EPP_WAIT out). It takes one byte-wide command at a time over a valid/ready interface and runs a full EPP address or data cycle (write or read). Each cycle is a four-phase strobe/WAIT handshake with a timeout. It instantiates in TB_FPGA_TOP to replace the tied-off strobes, and is reused in a host-emulation harness.

## Interface
- SETUP_CYCLES, 2, cycles WRITE/data are driven before the strobe falls (≥1)
- TIMEOUT_CYCLES, 1024, max cycles waited per WAIT edge before abort (≥4)
- CLK  in  1  system clock; all logic on rising edge
- RST_ASYNC  in  1  asynchronous, active-high reset
- CMD_VALID_IN  in  1  command present
- CMD_READY_OUT  out  1  high only in IDLE; accept = VALID & READY
- CMD_ADDR_IN  in  1  1 = address cycle (ASTB), 0 = data cycle (DSTB)
- CMD_WRITE_IN  in  1  1 = write, 0 = read
- CMD_WDATA_IN  in  8  write byte
- DONE_OUT  out  1  one-cycle pulse when a command completes or aborts
- ERR_OUT  out  1  valid with DONE_OUT; 1 = timeout
- RD_DATA_OUT  out  8  last captured read byte, held
- EPP_ASTB_OUT / EPP_DSTB_OUT  out  1 each  active-low strobes
- EPP_WRITE_OUT  out  1  active-low write
- EPP_DATA_OUT  out  8  host data; EPP_DATA_OE_OUT  out  1  drive enable
- EPP_DATA_IN  in  8  peripheral data
- EPP_WAIT_IN  in  1  peripheral WAIT, asynchronous; 2-flop synchronised internally

## Operation
- States: IDLE, SETUP, STROBE, RELEASE, DONE.
- IDLE: READY=1. On accept, latch the command:
  - EPP_WRITE_OUT = ~CMD_WRITE_IN.
  - For a write: EPP_DATA_OUT = WDATA and OE=1.
  - Load the setup counter and enter SETUP.
- SETUP: count SETUP_CYCLES. On the last cycle, register the selected strobe low (ASTB if ADDR, else DSTB) and enter STROBE.
- STROBE: wait for synchronised WAIT=1.
  - When seen: deassert the strobe. For a read, capture EPP_DATA_IN into RD_DATA_OUT on the same edge. Enter RELEASE.
- RELEASE: wait for synchronised WAIT=0.
  - When seen: release OE, set WRITE=1, data=0, and enter DONE.
- DONE: DONE_OUT=1 for one cycle with ERR_OUT set by the abort flag, then return to IDLE.
- Timeout counter: cleared on entry to STROBE and on entry to RELEASE; increments each cycle in those states. On reaching TIMEOUT_CYCLES:
  - strobe high, OE=0, WRITE=1;
  - set the abort flag and go to DONE.
  - RD_DATA_OUT is not updated on abort.
- Exactly one strobe is ever low. Neither strobe is low outside STROBE.
- Read with WAIT already high at strobe assertion (stale): it is treated as acknowledge. The peripheral is required to drop WAIT before the next strobe.

## Timing
- Reset values (immediate, async):
  - strobes=1, WRITE=1, DATA_OUT=0, OE=0;
  - DONE=0, ERR=0, RD_DATA=0x00;
  - state IDLE, so READY=1.
- Accept edge = cycle 0. WRITE, DATA, OE are valid from cycle 1.
- Strobe is low from cycle SETUP_CYCLES+1.
- Peripheral WAIT rising at cycle k:
  - sync value seen at k+2;
  - strobe high from k+3;
  - read data captured at edge k+2 (the peripheral holds data while WAIT is high).
- WAIT falling at cycle m: OE/WRITE released from m+3; DONE_OUT high in cycle m+3.
- READY returns the cycle after DONE. Minimum back-to-back spacing = DONE cycle + 1 idle cycle.
- CMD_* inputs are ignored outside the accept cycle.
- Reset mid-cycle: strobes rise asynchronously, no DONE pulse, command lost.

## Test plan
- Address write 0x05, responder raises WAIT 3 cycles after ASTB falls and drops it 2 cycles after ASTB rises:
  - ASTB low from cycle 3, WRITE=0, DATA=0x05 throughout;
  - DONE=1, ERR=0;
  - DSTB never low.
- Data read, responder drives 0xA5 with WAIT:
  - DSTB low, WRITE=1, OE=0;
  - RD_DATA_OUT=0xA5 at DONE, ERR=0.
- WAIT never rises, TIMEOUT_CYCLES=16:
  - strobe high after 16 cycles in STROBE;
  - DONE with ERR=1; RD_DATA unchanged.
- WAIT stuck high after strobe release:
  - RELEASE times out, DONE with ERR=1, OE=0.
- Back-to-back address write 0x01 then data write 0x3C with CMD_VALID held:
  - second accept one cycle after DONE;
  - strobes are never simultaneously low.
- RST_ASYNC pulsed while DSTB is low:
  - DSTB=1 and OE=0 in the same time step, no DONE pulse;
  - after reset a new read completes normally.
